// File: rtl/gate_sweep_checker_if.sv
// rtl/gate_sweep_checker_if.sv - stimulus/response and result bundle for gate_sweep_checker
// master = environment side (start, gate response); slave = checker side.
interface gate_sweep_checker_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic            resp_in;
   logic [N_IN-1:0] stim_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_fail_vec;
   logic            first_fail_valid;

   modport master (
      output start,
      output resp_in,
      input  stim_out,
      input  busy,
      input  done,
      input  pass,
      input  err_count,
      input  first_fail_vec,
      input  first_fail_valid
   );

   modport slave (
      input  start,
      input  resp_in,
      output stim_out,
      output busy,
      output done,
      output pass,
      output err_count,
      output first_fail_vec,
      output first_fail_valid
   );
endinterface

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive truth-table sweep of a small combinational gate
// Drives every input vector, waits a settle interval, samples and compares against EXPECT_MASK.
module gate_sweep_checker #(
   parameter int                         N_IN          = 2,
   parameter int                         SETTLE_CYCLES = 4,
   parameter logic [(2**N_IN)-1:0]       EXPECT_MASK   = 4'b1000
) (
   input  logic                 clk,
   input  logic                 rst,
   gate_sweep_checker_if.slave  bus
);

   localparam int              CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [N_IN-1:0] LAST_VEC    = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] stim_q, stim_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] ffv_q, ffv_d;
   logic            ffvalid_q, ffvalid_d;
   logic            pass_q, pass_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            mismatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         stim_q    <= '0;
         cnt_q     <= '0;
         err_q     <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
         pass_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         stim_q    <= stim_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
         pass_q    <= pass_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stim_d    = stim_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;
      pass_d    = pass_q;
      done_d    = 1'b0;
      mismatch  = (bus.resp_in != EXPECT_MASK[stim_q]);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = SETTLE;
               stim_d    = '0;
               cnt_d     = '0;
               err_d     = '0;
               ffv_d     = '0;
               ffvalid_d = 1'b0;
               pass_d    = 1'b0;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            if (mismatch) begin
               err_d = err_q + 1'b1;
               if (!ffvalid_q) begin
                  ffv_d     = stim_q;
                  ffvalid_d = 1'b1;
               end
            end
            // pass must reflect the count including this final sample
            if (stim_q == LAST_VEC) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d = SETTLE;
               stim_d  = stim_q + 1'b1;
               cnt_d   = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
   end

   assign bus.stim_out         = stim_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.pass             = pass_q;
   assign bus.err_count        = err_q;
   assign bus.first_fail_vec   = ffv_q;
   assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - bench for gate_sweep_checker
// Gates under test are modelled as truth tables indexed by stim_out.
module tb_gate_sweep_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] tt_a = 4'b1000;
   logic [7:0] tt_b = 8'h80;
   int         n_total = 0;
   int         n_pass  = 0;

   always #5 clk = ~clk;

   gate_sweep_checker_if #(.N_IN(2)) bus_a ();
   gate_sweep_checker_if #(.N_IN(3)) bus_b ();

   assign bus_a.resp_in = tt_a[bus_a.stim_out];
   assign bus_b.resp_in = tt_b[bus_b.stim_out];

   gate_sweep_checker #(.N_IN(2), .SETTLE_CYCLES(4), .EXPECT_MASK(4'b1000)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   gate_sweep_checker #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECT_MASK(8'h80)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   typedef struct {
      string      name;
      logic [3:0] tt;
      int         pulse_at;
      int         err;
      int         ffv;
      int         ffvalid;
      int         pss;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference: mismatches are simply the positions where table and mask differ.
   task automatic model(input logic [7:0] tt, input logic [7:0] mask, input int n,
                        output int err, output int ffv, output int ffvalid, output int pss);
      err = 0; ffv = 0; ffvalid = 0;
      for (int v = 0; v < (1 << n); v++) begin
         if (tt[v] != mask[v]) begin
            err++;
            if (ffvalid == 0) begin
               ffv     = v;
               ffvalid = 1;
            end
         end
      end
      pss = (err == 0) ? 1 : 0;
   endtask

   function automatic int outs_a();
      return {bus_a.stim_out, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
              bus_a.first_fail_vec, bus_a.first_fail_valid};
   endfunction

   function automatic int outs_b();
      return {bus_b.stim_out, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count,
              bus_b.first_fail_vec, bus_b.first_fail_valid};
   endfunction

   // Called at a negedge with dut_a idle; returns at the negedge after the done cycle.
   task automatic sweep_a(input string name, input logic [3:0] tt, input int pulse_at,
                          input int e_err, input int e_ffv, input int e_ffvalid, input int e_pass);
      int act_code, exp_code, first_j;
      first_j  = -1;
      act_code = 0;
      exp_code = 0;
      tt_a = tt;
      bus_a.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int j = 0; j < 20; j++) begin
         int a, e;
         bus_a.start = (j == pulse_at);
         a = {bus_a.stim_out, bus_a.busy, bus_a.done};
         e = ((j / 5) << 2) | 2;
         if (first_j < 0 && (a != e || j == 19)) begin
            first_j  = j;
            act_code = a;
            exp_code = e;
         end
         @(negedge clk);
      end
      bus_a.start = 1'b0;
      chk($sformatf("%s trace{stim,busy,done}@%0d", name, first_j), act_code, exp_code);
      chk($sformatf("%s done", name), int'(bus_a.done), 1);
      chk($sformatf("%s busy_at_done", name), int'(bus_a.busy), 0);
      chk($sformatf("%s stim_last", name), int'(bus_a.stim_out), 3);
      chk($sformatf("%s err_count", name), int'(bus_a.err_count), e_err);
      chk($sformatf("%s first_fail_vec", name), int'(bus_a.first_fail_vec), e_ffv);
      chk($sformatf("%s first_fail_valid", name), int'(bus_a.first_fail_valid), e_ffvalid);
      chk($sformatf("%s pass", name), int'(bus_a.pass), e_pass);
      @(negedge clk);
      chk($sformatf("%s done_single", name), int'(bus_a.done), 0);
      chk($sformatf("%s pass_held", name), int'(bus_a.pass), e_pass);
   endtask

   task automatic sweep_b(input string name, input logic [7:0] tt,
                          input int e_err, input int e_ffv, input int e_ffvalid, input int e_pass);
      int t;
      tt_b = tt;
      bus_b.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_b.start = 1'b0;
      t = 0;
      while (!bus_b.done && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("%s done_latency", name), t, 16);
      chk($sformatf("%s err_count", name), int'(bus_b.err_count), e_err);
      chk($sformatf("%s first_fail_vec", name), int'(bus_b.first_fail_vec), e_ffv);
      chk($sformatf("%s first_fail_valid", name), int'(bus_b.first_fail_valid), e_ffvalid);
      chk($sformatf("%s pass", name), int'(bus_b.pass), e_pass);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e_err, e_ffv, e_ffvalid, e_pass, t, done_seen;
      logic [7:0] rt;

      tbl[0] = '{"good_and",   4'b1000, -1, 0, 0, 0, 1};
      tbl[1] = '{"stuck0",     4'b0000, -1, 1, 3, 1, 0};
      tbl[2] = '{"nand",       4'b0111, -1, 4, 0, 1, 0};
      tbl[3] = '{"stuck1",     4'b1111, -1, 3, 0, 1, 0};
      tbl[4] = '{"good_after", 4'b1000, -1, 0, 0, 0, 1};
      tbl[5] = '{"repulse",    4'b1000,  6, 0, 0, 0, 1};

      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("reset outputs_a", outs_a(), 0);
      chk("reset outputs_b", outs_b(), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++)
         sweep_a(tbl[i].name, tbl[i].tt, tbl[i].pulse_at,
                 tbl[i].err, tbl[i].ffv, tbl[i].ffvalid, tbl[i].pss);

      // Async reset while stim_out==2 in SETTLE, with partial errors already recorded
      tt_a = 4'b0111;
      bus_a.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (11) @(negedge clk);
      chk("abort pre stim", int'(bus_a.stim_out), 2);
      chk("abort pre err", int'(bus_a.err_count), 2);
      #2 rst = 1'b1;
      #1;
      chk("abort outputs_zero", outs_a(), 0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      for (int j = 0; j < 25; j++) begin
         @(negedge clk);
         if (bus_a.done) done_seen++;
      end
      chk("abort no_done", done_seen, 0);
      chk("abort idle_busy", int'(bus_a.busy), 0);
      sweep_a("post_abort", 4'b1000, -1, 0, 0, 0, 1);

      // start held high: restart on the first IDLE edge, results cleared there
      tt_a = 4'b0000;
      bus_a.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      repeat (20) @(negedge clk);
      chk("held done", int'(bus_a.done), 1);
      chk("held err", int'(bus_a.err_count), 1);
      @(negedge clk);
      chk("held idle_busy", int'(bus_a.busy), 0);
      chk("held err_kept", int'(bus_a.err_count), 1);
      @(negedge clk);
      chk("held restart_busy", int'(bus_a.busy), 1);
      chk("held cleared", {bus_a.err_count, bus_a.first_fail_valid, bus_a.pass}, 0);
      bus_a.start = 1'b0;
      t = 0;
      while (!bus_a.done && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("held second_latency", t, 20);
      chk("held second_err", int'(bus_a.err_count), 1);
      chk("held second_ffv", int'(bus_a.first_fail_vec), 3);
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         rt = 8'($urandom_range(0, 15));
         model(rt, 8'h08, 2, e_err, e_ffv, e_ffvalid, e_pass);
         sweep_a($sformatf("rand_a%0d_tt%0h", i, rt), rt[3:0], -1, e_err, e_ffv, e_ffvalid, e_pass);
      end

      sweep_b("b_good_and3", 8'h80, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         rt = 8'($urandom_range(0, 255));
         model(rt, 8'h80, 3, e_err, e_ffv, e_ffvalid, e_pass);
         sweep_b($sformatf("rand_b%0d_tt%0h", i, rt), rt, e_err, e_ffv, e_ffvalid, e_pass);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
